// File: rtl/gerador_imediato.sv
// gerador_imediato: registered immediate generator for the nRisc decode stage.
// Define EXTENSOR_PREFIX_EN to let PREFIX instructions build wide constants.
module gerador_imediato #(
  parameter int         INSTR_W    = 8,
  parameter int         DATA_W     = 16,
  parameter int         MAX_PREFIX = 2,
  parameter logic [2:0] PREFIX_OP  = 3'b111
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction_received,
  input  logic               sign_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  immediate,
  output logic [2:0]         opcode_out,
  output logic               overflow
);

  // Raw is sized for the widest prefixed immediate so the enabled build never loses bits early.
  localparam int RW = 5 * MAX_PREFIX + 5;

  logic [2:0]        opcode;
  logic              accept;
  logic [4:0]        field;
  int                fw;
  int                t_w;
  logic [RW-1:0]     raw;
  logic              sign_bit;
  logic              zero_imm;
  logic [DATA_W-1:0] ext;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [2:0]        op_q, op_d;
  logic              ovf_q, ovf_d;

  assign opcode   = instruction_received[INSTR_W-1 -: 3];
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fw    = 0;
    field = '0;
    case (opcode)
      3'b000, 3'b010: begin fw = 3; field = {2'b00, instruction_received[2:0]}; end
      3'b001, 3'b100: begin fw = 4; field = {1'b0, instruction_received[3:0]}; end
      3'b101, 3'b110: begin fw = 5; field = instruction_received[4:0]; end
      default:        begin fw = 0; field = '0; end
    endcase
  end

`ifdef EXTENSOR_PREFIX_EN
  localparam int AW = 5 * MAX_PREFIX;
  localparam int CW = $clog2(MAX_PREFIX + 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_PREFIX = 1'b1;

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic [0:0]    state_q, state_d;
  logic          is_prefix;

  assign is_prefix = (opcode == PREFIX_OP);
  assign zero_imm  = (fw == 0);

  always_comb begin
    t_w = (state_q == ST_PREFIX) ? 5 * int'(cnt_q) + fw : fw;
    raw = (RW'(acc_q) << fw) | RW'(field);
  end
`else
  assign zero_imm = (fw == 0) || (opcode == PREFIX_OP);

  always_comb begin
    t_w = fw;
    raw = RW'(field);
  end
`endif

  // Bits below T come from raw; everything above is the sign bit or zero.
  always_comb begin
    sign_bit = (t_w > 0) ? raw[t_w-1] : 1'b0;
    ext      = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < t_w)
        ext[i] = (i < RW) ? raw[i] : 1'b0;
      else
        ext[i] = sign_mode & sign_bit;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    imm_d       = imm_q;
    op_d        = op_q;
    ovf_d       = ovf_q;
`ifdef EXTENSOR_PREFIX_EN
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    state_d     = state_q;
`endif
    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;
    if (accept) begin
`ifdef EXTENSOR_PREFIX_EN
      if (is_prefix) begin
        if (cnt_q == CW'(MAX_PREFIX)) begin
          drop_d = 1'b1;
        end else begin
          acc_d = (acc_q << 5) | AW'(instruction_received[4:0]);
          cnt_d = cnt_q + CW'(1);
        end
        state_d = ST_PREFIX;
      end else begin
        out_valid_d = 1'b1;
        imm_d       = zero_imm ? '0 : ext;
        op_d        = opcode;
        ovf_d       = (t_w > DATA_W) || drop_q;
        acc_d       = '0;
        cnt_d       = '0;
        drop_d      = 1'b0;
        state_d     = ST_IDLE;
      end
`else
      out_valid_d = 1'b1;
      imm_d       = zero_imm ? '0 : ext;
      op_d        = opcode;
      ovf_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      op_q        <= '0;
      ovf_q       <= 1'b0;
`ifdef EXTENSOR_PREFIX_EN
      acc_q       <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      state_q     <= ST_IDLE;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      op_q        <= op_d;
      ovf_q       <= ovf_d;
`ifdef EXTENSOR_PREFIX_EN
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign immediate  = imm_q;
  assign opcode_out = op_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_gerador_imediato.sv
// Directed bench for gerador_imediato; prefix expectations follow EXTENSOR_PREFIX_EN.
module tb_gerador_imediato;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  instruction_received = '0;
  logic        sign_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] immediate;
  logic [2:0]  opcode_out;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  gerador_imediato #(.INSTR_W(8), .DATA_W(16), .MAX_PREFIX(2), .PREFIX_OP(3'b111)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_received(instruction_received), .sign_mode(sign_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .immediate(immediate), .opcode_out(opcode_out), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  instr;
    logic        sm;
    logic [15:0] imm;
    logic [2:0]  op;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] imm, input logic [2:0] op, input logic ovf);
    check({name, ".valid"}, 16'(out_valid), 16'h1);
    check({name, ".imm"}, immediate, imm);
    check({name, ".op"}, 16'(opcode_out), 16'(op));
    check({name, ".ovf"}, 16'(overflow), 16'(ovf));
  endtask

  // One accepted instruction; returns at the negedge after the capturing edge.
  task automatic send(input logic [7:0] instr, input logic sm);
    @(negedge clock);
    in_valid = 1'b1;
    instruction_received = instr;
    sign_mode = sm;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'b100_0_1011, 1'b0, 16'h000B, 3'b100, 1'b0};
    vecs[1] = '{8'b100_0_1011, 1'b1, 16'hFFFB, 3'b100, 1'b0};
    vecs[2] = '{8'b000_00_101, 1'b1, 16'hFFFD, 3'b000, 1'b0};
    vecs[3] = '{8'b000_11_010, 1'b0, 16'h0002, 3'b000, 1'b0};
    vecs[4] = '{8'b010_00_011, 1'b1, 16'h0003, 3'b010, 1'b0};
    vecs[5] = '{8'b001_0_1111, 1'b0, 16'h000F, 3'b001, 1'b0};
    vecs[6] = '{8'b101_10000, 1'b1, 16'hFFF0, 3'b101, 1'b0};
    vecs[7] = '{8'b110_01111, 1'b1, 16'h000F, 3'b110, 1'b0};
    vecs[8] = '{8'b110_11111, 1'b0, 16'h001F, 3'b110, 1'b0};
    vecs[9] = '{8'b011_11111, 1'b1, 16'h0000, 3'b011, 1'b0};

    // Reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset.valid", 16'(out_valid), 16'h0);
    check("reset.imm", immediate, 16'h0000);
    check("reset.ovf", 16'(overflow), 16'h0);
    check("reset.in_ready", 16'(in_ready), 16'h1);

    // Back-to-back table: one instruction per cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i > 0) check_out($sformatf("vec%0d", i - 1), vecs[i-1].imm, vecs[i-1].op, vecs[i-1].ovf);
      in_valid = 1'b1;
      instruction_received = vecs[i].instr;
      sign_mode = vecs[i].sm;
    end
    @(negedge clock);
    check_out("vec9", vecs[9].imm, vecs[9].op, vecs[9].ovf);
    in_valid = 1'b0;
    @(negedge clock);
    check("drain.valid", 16'(out_valid), 16'h0);

    // Backpressure: output held, input stalled, then accepted when out_ready rises
    send(8'b100_0_0001, 1'b0);
    check_out("bp.first", 16'h0001, 3'b100, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction_received = 8'b100_0_0010;
    sign_mode = 1'b0;
    #1 check("bp.in_ready_low", 16'(in_ready), 16'h0);
    @(negedge clock);
    check_out("bp.hold", 16'h0001, 3'b100, 1'b0);
    out_ready = 1'b1;
    #1 check("bp.in_ready_high", 16'(in_ready), 16'h1);
    @(negedge clock);
    in_valid = 1'b0;
    check_out("bp.second", 16'h0002, 3'b100, 1'b0);
    @(negedge clock);
    check("bp.drain", 16'(out_valid), 16'h0);

`ifdef EXTENSOR_PREFIX_EN
    // PREFIX then beq
    send(8'b111_00011, 1'b0);
    check("pfx.no_out", 16'(out_valid), 16'h0);
    send(8'b101_10101, 1'b0);
    check_out("pfx.beq", 16'h0075, 3'b101, 1'b0);

    // Three PREFIXes: third dropped, overflow flagged; next instruction clean
    send(8'b111_11111, 1'b1);
    check("drop.p1_no_out", 16'(out_valid), 16'h0);
    send(8'b111_11111, 1'b1);
    send(8'b111_11111, 1'b1);
    check("drop.p3_no_out", 16'(out_valid), 16'h0);
    send(8'b010_00_111, 1'b1);
    check_out("drop.load", 16'hFFFF, 3'b010, 1'b1);
    send(8'b100_0_0001, 1'b0);
    check_out("drop.after", 16'h0001, 3'b100, 1'b0);

    // Opcode 011 after a prefix still yields zero and clears prefix state
    send(8'b111_10101, 1'b1);
    send(8'b011_11111, 1'b1);
    check_out("z011.pfx", 16'h0000, 3'b011, 1'b0);
    send(8'b100_0_0011, 1'b0);
    check_out("z011.after", 16'h0003, 3'b100, 1'b0);
`else
    // Opcode 111 is an ordinary zero-immediate instruction
    send(8'b111_00011, 1'b0);
    check_out("pfx.plain", 16'h0000, 3'b111, 1'b0);
    send(8'b101_10101, 1'b0);
    check_out("pfx.beq", 16'h0015, 3'b101, 1'b0);

    send(8'b111_11111, 1'b1);
    check_out("drop.p1", 16'h0000, 3'b111, 1'b0);
    send(8'b010_00_111, 1'b1);
    check_out("drop.load", 16'hFFFF, 3'b010, 1'b0);
    send(8'b100_0_0001, 1'b0);
    check_out("drop.after", 16'h0001, 3'b100, 1'b0);
`endif

    // Reset after a PREFIX discards it; reset also wins over a valid input
    send(8'b111_00001, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b1;
    instruction_received = 8'b100_0_1111;
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    check("rst.valid", 16'(out_valid), 16'h0);
    check("rst.imm", immediate, 16'h0000);
    send(8'b100_0_0101, 1'b0);
    check_out("rst.addi", 16'h0005, 3'b100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
